decoder_8b10b: RTL and testbench

DECODER_8B10B -- requirements
Module: decoder_8b10b

---
 rtl/decoder_8b10b_if.sv | 30 +++
 rtl/decoder_8b10b.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_decoder_8b10b.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/decoder_8b10b_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : decoder_8b10b_if                                          |
// | Purpose  : Bundle of the 8b/10b decoder receive and result signals.  |
// |            master = code-group source, slave = decoder.              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface decoder_8b10b_if;
  logic [9:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       k_out;
  logic       dout_valid;
  logic       code_err;
  logic       disp_err;
  logic       rd_out;
  logic       sync;

  modport master (
    output din, din_valid,
    input  dout, k_out, dout_valid, code_err, disp_err, rd_out, sync
  );

  modport slave (
    input  din, din_valid,
    output dout, k_out, dout_valid, code_err, disp_err, rd_out, sync
  );
endinterface
`default_nettype wire

// File: rtl/decoder_8b10b.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : decoder_8b10b                                             |
// | Purpose  : 10b->8b decoder with running-disparity tracking, code and |
// |            disparity error flags, and a comma-based sync FSM.        |
// |            One cycle of latency from din_valid to dout_valid.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module decoder_8b10b (
  input  logic           clk,
  input  logic           rst_n,
  decoder_8b10b_if.slave dec_if
);

  typedef enum logic [1:0] {
    LOSS_OF_SYNC = 2'd0,
    COMMA_DET    = 2'd1,
    SYNC_ACQ     = 2'd2
  } state_t;

  // 5b/6b table, both disparity forms: returns {valid, x}
  function automatic logic [5:0] dec6(input logic [5:0] c);
    logic [5:0] r;
    r = 6'b0;
    case (c)
      6'b100111, 6'b011000: r = {1'b1, 5'd0};
      6'b011101, 6'b100010: r = {1'b1, 5'd1};
      6'b101101, 6'b010010: r = {1'b1, 5'd2};
      6'b110001:            r = {1'b1, 5'd3};
      6'b110101, 6'b001010: r = {1'b1, 5'd4};
      6'b101001:            r = {1'b1, 5'd5};
      6'b011001:            r = {1'b1, 5'd6};
      6'b111000, 6'b000111: r = {1'b1, 5'd7};
      6'b111001, 6'b000110: r = {1'b1, 5'd8};
      6'b100101:            r = {1'b1, 5'd9};
      6'b010101:            r = {1'b1, 5'd10};
      6'b110100:            r = {1'b1, 5'd11};
      6'b001101:            r = {1'b1, 5'd12};
      6'b101100:            r = {1'b1, 5'd13};
      6'b011100:            r = {1'b1, 5'd14};
      6'b010111, 6'b101000: r = {1'b1, 5'd15};
      6'b011011, 6'b100100: r = {1'b1, 5'd16};
      6'b100011:            r = {1'b1, 5'd17};
      6'b010011:            r = {1'b1, 5'd18};
      6'b110010:            r = {1'b1, 5'd19};
      6'b001011:            r = {1'b1, 5'd20};
      6'b101010:            r = {1'b1, 5'd21};
      6'b011010:            r = {1'b1, 5'd22};
      6'b111010, 6'b000101: r = {1'b1, 5'd23};
      6'b110011, 6'b001100: r = {1'b1, 5'd24};
      6'b100110:            r = {1'b1, 5'd25};
      6'b010110:            r = {1'b1, 5'd26};
      6'b110110, 6'b001001: r = {1'b1, 5'd27};
      6'b001110, 6'b001111,
      6'b110000:            r = {1'b1, 5'd28};
      6'b101110, 6'b010001: r = {1'b1, 5'd29};
      6'b011110, 6'b100001: r = {1'b1, 5'd30};
      6'b101011, 6'b010100: r = {1'b1, 5'd31};
      default:              r = 6'b0;
    endcase
    return r;
  endfunction

  // 3b/4b table, both disparity forms (primary and alternate .7): {valid, y}
  function automatic logic [3:0] dec4(input logic [3:0] c);
    logic [3:0] r;
    r = 4'b0;
    case (c)
      4'b1011, 4'b0100: r = {1'b1, 3'd0};
      4'b1001:          r = {1'b1, 3'd1};
      4'b0101:          r = {1'b1, 3'd2};
      4'b1100, 4'b0011: r = {1'b1, 3'd3};
      4'b1101, 4'b0010: r = {1'b1, 3'd4};
      4'b1010:          r = {1'b1, 3'd5};
      4'b0110:          r = {1'b1, 3'd6};
      4'b1110, 4'b0001,
      4'b0111, 4'b1000: r = {1'b1, 3'd7};
      default:          r = 4'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Registered state
  logic [7:0] dout_q;
  logic       k_q, code_err_q, disp_err_q, dout_valid_q, rd_q, sync_q;
  state_t     state_q, state_d;
  logic [1:0] comma_cnt_q, comma_cnt_d;
  logic [1:0] err_cnt_q, err_cnt_d;
  logic [1:0] good_cnt_q, good_cnt_d;
  logic       sync_d;

  // Decode wires
  logic [5:0] w_c6;
  logic [3:0] w_c4, w_f4;
  logic       w_v6, w_v4;
  logic [4:0] w_x;
  logic [2:0] w_y;
  logic [7:0] w_byte;
  logic       w_k28, w_ei_neg, w_ei_pos, w_kpos6, w_kneg6;
  logic       w_a7m, w_a7p, w_p7m, w_p7p;
  logic       w_combo_err, w_code_err, w_is_k, w_comma, w_grp_err;
  logic [2:0] w_n6, w_n4;
  logic       w_rd_mid, w_rd_end, w_derr6, w_derr4, w_disp_err;

  assign w_c6 = dec_if.din[9:4];   // a b c d e i
  assign w_c4 = dec_if.din[3:0];   // f g h j

  // K.28 shares 4b codes with D but in mirrored disparity; the RD+ form
  // (110000) is folded onto the D table by complementing fghj.
  assign w_k28 = (w_c6 == 6'b001111) || (w_c6 == 6'b110000);
  assign w_f4  = (w_c6 == 6'b110000) ? ~w_c4 : w_c4;

  assign {w_v6, w_x} = dec6(w_c6);
  assign {w_v4, w_y} = dec4(w_f4);
  assign w_byte      = {w_y, w_x};

  // 6b codes that must take the alternate .7 form (to avoid a run of five)
  assign w_ei_neg = (w_c6 == 6'b100011) || (w_c6 == 6'b010011) || (w_c6 == 6'b001011);
  assign w_ei_pos = (w_c6 == 6'b110100) || (w_c6 == 6'b101100) || (w_c6 == 6'b011100);
  // 6b halves of the K.x.7 set, split by which alternate 4b they pair with
  assign w_kpos6  = (w_c6 == 6'b111010) || (w_c6 == 6'b110110) || (w_c6 == 6'b101110) ||
                    (w_c6 == 6'b011110) || (w_c6 == 6'b001111);
  assign w_kneg6  = (w_c6 == 6'b000101) || (w_c6 == 6'b001001) || (w_c6 == 6'b010001) ||
                    (w_c6 == 6'b100001) || (w_c6 == 6'b110000);

  assign w_a7m = (w_c4 == 4'b0111);
  assign w_a7p = (w_c4 == 4'b1000);
  assign w_p7m = (w_c4 == 4'b1110);
  assign w_p7p = (w_c4 == 4'b0001);

  assign w_combo_err = (w_k28 & (w_p7m | w_p7p))
                     | (w_a7m & ~(w_ei_neg | w_kneg6))
                     | (w_a7p & ~(w_ei_pos | w_kpos6))
                     | (w_p7m & w_ei_neg)
                     | (w_p7p & w_ei_pos);

  assign w_code_err = ~w_v6 | ~w_v4 | w_combo_err;
  assign w_is_k     = w_k28 | (w_a7m & w_kneg6) | (w_a7p & w_kpos6);

  // Running disparity: 6b sub-block first, then 4b from the mid-point RD
  always_comb begin
    w_n6     = ones6(w_c6);
    w_n4     = ones4(w_c4);
    w_rd_mid = rd_q;
    w_derr6  = 1'b0;
    w_rd_end = 1'b0;
    w_derr4  = 1'b0;
    if (w_n6 > 3'd3) begin
      w_derr6  = rd_q;
      w_rd_mid = 1'b1;
    end else if (w_n6 < 3'd3) begin
      w_derr6  = ~rd_q;
      w_rd_mid = 1'b0;
    end else if (w_c6 == 6'b000111) begin
      w_derr6  = ~rd_q;
      w_rd_mid = 1'b1;
    end else if (w_c6 == 6'b111000) begin
      w_derr6  = rd_q;
      w_rd_mid = 1'b0;
    end
    w_rd_end = w_rd_mid;
    if (w_n4 > 3'd2) begin
      w_derr4  = w_rd_mid;
      w_rd_end = 1'b1;
    end else if (w_n4 < 3'd2) begin
      w_derr4  = ~w_rd_mid;
      w_rd_end = 1'b0;
    end else if (w_c4 == 4'b0011) begin
      w_derr4  = ~w_rd_mid;
      w_rd_end = 1'b1;
    end else if (w_c4 == 4'b1100) begin
      w_derr4  = w_rd_mid;
      w_rd_end = 1'b0;
    end
    w_disp_err = w_derr6 | w_derr4;
  end

  assign w_grp_err = w_code_err | w_disp_err;
  assign w_comma   = ~w_grp_err & w_is_k & (w_byte == 8'hBC);

  // Sync FSM next state and counters; only valid groups advance it
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    if (dec_if.din_valid) begin
      case (state_q)
        LOSS_OF_SYNC: begin
          if (w_comma) begin
            state_d     = COMMA_DET;
            comma_cnt_d = 2'd1;
          end
        end
        COMMA_DET: begin
          if (w_grp_err) begin
            state_d     = LOSS_OF_SYNC;
            comma_cnt_d = 2'd0;
          end else if (w_comma) begin
            if (comma_cnt_q == 2'd2) begin
              state_d     = SYNC_ACQ;
              comma_cnt_d = 2'd0;
              err_cnt_d   = 2'd0;
              good_cnt_d  = 2'd0;
            end else begin
              comma_cnt_d = comma_cnt_q + 2'd1;
            end
          end
        end
        SYNC_ACQ: begin
          if (w_grp_err) begin
            good_cnt_d = 2'd0;
            if (err_cnt_q == 2'd3) begin
              state_d   = LOSS_OF_SYNC;
              err_cnt_d = 2'd0;
            end else begin
              err_cnt_d = err_cnt_q + 2'd1;
            end
          end else if (good_cnt_q == 2'd3) begin
            good_cnt_d = 2'd0;
            if (err_cnt_q != 2'd0) err_cnt_d = err_cnt_q - 2'd1;
          end else begin
            good_cnt_d = good_cnt_q + 2'd1;
          end
        end
        default: begin
          state_d     = LOSS_OF_SYNC;
          comma_cnt_d = 2'd0;
          err_cnt_d   = 2'd0;
          good_cnt_d  = 2'd0;
        end
      endcase
    end
    sync_d = (state_d == SYNC_ACQ);
  end

  // Sync FSM state, counters and registered sync flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOSS_OF_SYNC;
      comma_cnt_q <= 2'd0;
      err_cnt_q   <= 2'd0;
      good_cnt_q  <= 2'd0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      sync_q      <= sync_d;
    end
  end

  // Result registers; held (and RD frozen) while din_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= 8'h00;
      k_q          <= 1'b0;
      code_err_q   <= 1'b0;
      disp_err_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      dout_valid_q <= dec_if.din_valid;
      if (dec_if.din_valid) begin
        dout_q     <= w_code_err ? 8'h00 : w_byte;
        k_q        <= ~w_code_err & w_is_k;
        code_err_q <= w_code_err;
        disp_err_q <= w_disp_err;
        rd_q       <= w_rd_end;
      end
    end
  end

  assign dec_if.dout       = dout_q;
  assign dec_if.k_out      = k_q;
  assign dec_if.dout_valid = dout_valid_q;
  assign dec_if.code_err   = code_err_q;
  assign dec_if.disp_err   = disp_err_q;
  assign dec_if.rd_out     = rd_q;
  assign dec_if.sync       = sync_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_8b10b.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_decoder_8b10b                                          |
// | Purpose  : Directed vector table plus hand-written sync and reset    |
// |            sequences for decoder_8b10b.                              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_decoder_8b10b;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  decoder_8b10b_if dif ();

  decoder_8b10b u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] din;
    logic       vld;
    logic [7:0] dout;
    logic       k;
    logic       ce;
    logic       de;
    logic       rd;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  // {dout_valid, dout, k_out, code_err, disp_err, rd_out, sync}
  function automatic logic [13:0] snap();
    return {dif.dout_valid, dif.dout, dif.k_out, dif.code_err,
            dif.disp_err, dif.rd_out, dif.sync};
  endfunction

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got {vld,dout,k,ce,de,rd,sync}=%b_%h_%b%b%b%b%b expected %b_%h_%b%b%b%b%b",
               nm, act[13], act[12:5], act[4], act[3], act[2], act[1], act[0],
               exp[13], exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    else
      n_pass++;
  endtask

  task automatic check_sync(input string nm, input logic exp);
    n_total++;
    if (dif.sync !== exp)
      $display("FAIL %s: sync got %b expected %b", nm, dif.sync, exp);
    else
      n_pass++;
  endtask

  task automatic step(input logic [9:0] d, input logic v);
    @(negedge clk);
    dif.din       = d;
    dif.din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    dif.din_valid = 1'b0;
    dif.din       = 10'h000;
    rst_n         = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    dif.din       = 10'h000;
    dif.din_valid = 1'b0;

    //           din      vld   dout   k     ce    de    rd
    tbl[0]  = '{10'h2AA, 1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0}; // D.21.5
    tbl[1]  = '{10'h274, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // D.0.0 RD-
    tbl[2]  = '{10'h0FA, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1}; // K.28.5 RD-
    tbl[3]  = '{10'h0FA, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1}; // K.28.5 RD- at RD+
    tbl[4]  = '{10'h000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0}; // all zeros
    tbl[5]  = '{10'h389, 1'b1, 8'h27, 1'b0, 1'b0, 1'b0, 1'b0}; // D.7.1, 111000 at RD-
    tbl[6]  = '{10'h079, 1'b1, 8'h27, 1'b0, 1'b0, 1'b1, 1'b1}; // 000111 at RD-
    tbl[7]  = '{10'h313, 1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 1'b1}; // D.3.3, 0011 at RD+
    tbl[8]  = '{10'h305, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0}; // K.28.5 RD+
    tbl[9]  = '{10'h237, 1'b1, 8'hF1, 1'b0, 1'b0, 1'b0, 1'b1}; // D.17.A7
    tbl[10] = '{10'h23E, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}; // D.17 with P7 1110
    tbl[11] = '{10'h057, 1'b1, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b1}; // K.23.7 RD+
    tbl[12] = '{10'h227, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1}; // D.1 with A7
    for (int i = 13; i < 18; i++)
      tbl[i] = '{10'h000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};  // idle: hold
    tbl[18] = '{10'h30B, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b1}; // K.28.0 RD+
    tbl[19] = '{10'h306, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0}; // K.28.1 RD+
    tbl[20] = '{10'h0F6, 1'b1, 8'hDC, 1'b1, 1'b0, 1'b0, 1'b1}; // K.28.6 RD-
    tbl[21] = '{10'h3FF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}; // all ones
    tbl[22] = '{10'h30E, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1}; // K.28 with P7
    tbl[23] = '{10'h348, 1'b1, 8'hEB, 1'b0, 1'b0, 1'b0, 1'b0}; // D.11.A7 at RD+

    // Reset state
    do_reset();
    #1;
    check("reset_state", snap(), 14'h0000);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].din, tbl[i].vld);
      check($sformatf("vec%0d_din%h", i, tbl[i].din), snap(),
            {tbl[i].vld, tbl[i].dout, tbl[i].k, tbl[i].ce, tbl[i].de, tbl[i].rd, 1'b0});
    end

    // Sync: non-comma holds COMMA_DET, idles do not advance it
    do_reset();
    step(10'h0FA, 1'b1); check_sync("sa_comma1", 1'b0);
    step(10'h2AA, 1'b1); check_sync("sa_noncomma", 1'b0);
    step(10'h305, 1'b1); check_sync("sa_comma2", 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(10'h000, 1'b0); check_sync($sformatf("sa_idle%0d", i), 1'b0);
    end
    step(10'h0FA, 1'b1); check_sync("sa_comma3", 1'b1);
    // One error, then four good groups pay it back
    step(10'h000, 1'b1); check_sync("sa_err1", 1'b1);
    for (int i = 0; i < 4; i++) begin
      step((i % 2 == 0) ? 10'h0FA : 10'h305, 1'b1);
      check_sync($sformatf("sa_good%0d", i), 1'b1);
    end
    // Three errors are tolerated, the fourth drops sync
    for (int i = 0; i < 3; i++) begin
      step(10'h000, 1'b1); check_sync($sformatf("sa_errb%0d", i), 1'b1);
    end
    step(10'h000, 1'b1); check_sync("sa_err_drop", 1'b0);

    // Alternating commas from reset, then four code errors
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 10'h0FA : 10'h305, 1'b1);
      check_sync($sformatf("sb_comma%0d", i), (i >= 2) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(10'h000, 1'b1);
      check_sync($sformatf("sb_err%0d", i), (i < 3) ? 1'b1 : 1'b0);
    end

    // Mid-stream asynchronous reset discards the group in flight
    step(10'h2AA, 1'b1);
    check("pre_reset", snap(), {1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    dif.din       = 10'h0FA;
    dif.din_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", snap(), 14'h0000);
    @(posedge clk);
    #1;
    check("reset_hold", snap(), 14'h0000);
    @(negedge clk);
    rst_n         = 1'b1;
    dif.din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_no_pulse", snap(), 14'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
